// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and address-width helper for the register file.
package rf_pkg;
    localparam int WIDTH_DEF    = 16;
    localparam int NUM_REGS_DEF = 8;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rf_entry.sv
// rf_entry: one register-file row with write enable and async active-low clear.
module rf_entry #(
    parameter int WIDTH = rf_pkg::WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_d, data_q;

    always_comb data_d = we ? d : data_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) data_q <= '0;
        else      data_q <= data_d;

    assign q = data_q;
endmodule

// File: rtl/rf_bypass.sv
// rf_bypass: NUM_REGS x WIDTH register file, two comb read ports, one write port,
// optional write-to-read bypass and out-of-range index error flag.
module rf_bypass
    import rf_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = addr_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read1_reg,
    input  logic [ADDR_W-1:0] read2_reg,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              write_en,
    output logic [WIDTH-1:0]  read1_data,
    output logic [WIDTH-1:0]  read2_data,
    output logic              err
);
    // One extra bit so NUM_REGS itself is representable in the range compare.
    localparam logic [ADDR_W:0] NREGS = (ADDR_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0] we_vec;
    logic [WIDTH-1:0]    rows [NUM_REGS];
    logic                wr_ok, rd1_ok, rd2_ok, byp1, byp2;

    always_comb begin
        wr_ok  = {1'b0, write_reg} < NREGS;
        rd1_ok = {1'b0, read1_reg} < NREGS;
        rd2_ok = {1'b0, read2_reg} < NREGS;
        byp1   = (BYPASS != 0) && write_en && (write_reg == read1_reg);
        byp2   = (BYPASS != 0) && write_en && (write_reg == read2_reg);
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_row
        assign we_vec[g] = write_en && wr_ok && (write_reg == ADDR_W'(g));
        rf_entry #(.WIDTH(WIDTH)) u_entry (
            .clk (clk),
            .rst (rst),
            .we  (we_vec[g]),
            .d   (write_data),
            .q   (rows[g])
        );
    end

    always_comb begin
        read1_data = (!rst || !rd1_ok) ? '0 : byp1 ? write_data : rows[read1_reg];
        read2_data = (!rst || !rd2_ok) ? '0 : byp2 ? write_data : rows[read2_reg];
        err        = rst && ((write_en && !wr_ok) || !rd1_ok || !rd2_ok);
    end
endmodule

// File: tb/tb_rf_bypass.sv
// tb_rf_bypass: scoreboard bench driving a bypassing 8-entry file and a
// non-bypassing 6-entry file with identical stimulus.
module tb_rf_bypass;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  r1, r2, wr;
    logic [15:0] wd;
    logic        we;
    logic [15:0] a1, a2, b1, b2;
    logic        ae, be;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        string       name;
        logic [15:0] a1, a2;
        logic        ae;
        logic [15:0] b1, b2;
        logic        be;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    rf_bypass dut_a (
        .clk(clk), .rst(rst), .read1_reg(r1), .read2_reg(r2), .write_reg(wr),
        .write_data(wd), .write_en(we), .read1_data(a1), .read2_data(a2), .err(ae)
    );

    rf_bypass #(.NUM_REGS(6), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .read1_reg(r1), .read2_reg(r2), .write_reg(wr),
        .write_data(wd), .write_en(we), .read1_data(b1), .read2_data(b2), .err(be)
    );

    task automatic cmp(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    // Monitor: samples 1 ns after each expectation is queued.
    initial forever begin
        exp_t e;
        wait (q.size() > 0);
        #1;
        e = q.pop_front();
        cmp({e.name, ".a.rd1"}, a1, e.a1);
        cmp({e.name, ".a.rd2"}, a2, e.a2);
        cmp({e.name, ".a.err"}, {15'd0, ae}, {15'd0, e.ae});
        cmp({e.name, ".b.rd1"}, b1, e.b1);
        cmp({e.name, ".b.rd2"}, b2, e.b2);
        cmp({e.name, ".b.err"}, {15'd0, be}, {15'd0, e.be});
    end

    task automatic drv(input int a, input int b, input logic e, input int w, input logic [15:0] d);
        r1 = 3'(a);
        r2 = 3'(b);
        we = e;
        wr = 3'(w);
        wd = d;
    endtask

    task automatic chk(input string n, input logic [15:0] x1, input logic [15:0] x2, input logic xe,
                       input logic [15:0] y1, input logic [15:0] y2, input logic ye);
        exp_t e;
        e.name = n; e.a1 = x1; e.a2 = x2; e.ae = xe; e.b1 = y1; e.b2 = y2; e.be = ye;
        q.push_back(e);
        #2;
    endtask

    initial begin
        logic [15:0] ref8 [8];
        ref8 = '{16'h0, 16'h0, 16'h7777, 16'h1234, 16'h0, 16'h5555, 16'h0, 16'hFFFF};
        rst = 1'b0;
        drv(3, 7, 1'b1, 3, 16'h1234);
        chk("in_reset", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            drv(i, i, 1'b1, i, 16'hBEEF);
            chk("fill", 16'hBEEF, 16'hBEEF, 1'b0, 16'h0, 16'h0, i >= 6);
        end
        @(negedge clk) drv(0, 5, 1'b0, 7, 16'h0);
        chk("hold", 16'hBEEF, 16'hBEEF, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0);
        @(negedge clk) rst = 1'b0;
        chk("rst_clr", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        drv(7, 6, 1'b0, 0, 16'h0);
        chk("rst_err", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk) drv(0, 5, 1'b0, 0, 16'h0);
        chk("post_rst", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk) drv(4, 4, 1'b1, 3, 16'h1234);
        chk("unwritten", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk) drv(3, 3, 1'b0, 0, 16'h0);
        chk("basic", 16'h1234, 16'h1234, 1'b0, 16'h1234, 16'h1234, 1'b0);
        @(negedge clk) drv(4, 4, 1'b1, 5, 16'h00AA);
        chk("w_r5", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk) drv(5, 3, 1'b1, 5, 16'h5555);
        chk("bypass", 16'h5555, 16'h1234, 1'b0, 16'h00AA, 16'h1234, 1'b0);
        @(negedge clk) drv(5, 5, 1'b0, 0, 16'h0);
        chk("after_byp", 16'h5555, 16'h5555, 1'b0, 16'h5555, 16'h5555, 1'b0);
        @(negedge clk) drv(2, 6, 1'b1, 2, 16'h7777);
        chk("dual", 16'h7777, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
        @(negedge clk) drv(2, 2, 1'b0, 0, 16'h0);
        chk("dual_st", 16'h7777, 16'h7777, 1'b0, 16'h7777, 16'h7777, 1'b0);
        @(negedge clk) drv(3, 5, 1'b1, 7, 16'hFFFF);
        chk("oor_wr", 16'h1234, 16'h5555, 1'b0, 16'h1234, 16'h5555, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) drv(i, i, 1'b0, 0, 16'h0);
            chk("sweep", ref8[i], ref8[i], 1'b0,
                (i < 6) ? ref8[i] : 16'h0, (i < 6) ? ref8[i] : 16'h0, i >= 6);
        end
        @(negedge clk) drv(1, 0, 1'b1, 1, 16'h4321);
        rst = 1'b0;
        chk("mid_rst", 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk) rst = 1'b1;
        drv(4, 1, 1'b1, 4, 16'h0A0A);
        chk("rel_wr", 16'h0A0A, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk) drv(4, 2, 1'b0, 0, 16'h0);
        chk("rel_st", 16'h0A0A, 16'h0, 1'b0, 16'h0A0A, 16'h0, 1'b0);
        for (int k = 0; k < 20 && q.size() > 0; k++) #1;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_bypass.md
# rf_bypass

Parametrised multi-entry register file with two combinational read ports, one synchronous write port, optional write-to-read bypass, and address-range error detection. It generalises the team's single write-enabled register into an indexed array. It sits in the decode stage of the processor and supplies both source operands per instruction. Writeback drives the write port.

## Interface
Parameters:
- WIDTH, 16, data width of each entry in bits
- NUM_REGS, 8, number of entries; need not be a power of two
- BYPASS, 1, 1 = a read of the entry being written returns write_data in the same cycle; 0 = the read returns the stored (old) value
- ADDR_W, derived localparam = max(1, clog2(NUM_REGS)), not overridable

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (clears all entries)
- read1_reg  in  ADDR_W  index for read port 1
- read2_reg  in  ADDR_W  index for read port 2
- write_reg  in  ADDR_W  index for the write port
- write_data  in  WIDTH  data to write
- write_en  in  1  write strobe, sampled at the rising edge of clk
- read1_data  out  WIDTH  data for read port 1
- read2_data  out  WIDTH  data for read port 2
- err  out  1  combinational error flag

## Operation
- Storage: NUM_REGS entries of WIDTH bits. Each entry is held by flops with asynchronous active-low clear.
- Write:
  - When rst=1 and write_en=1 and write_reg < NUM_REGS, entry[write_reg] takes write_data on the rising clk edge.
  - Otherwise, every entry holds its value.
- Read: readN_data is a combinational function of readN_reg and the current storage. Priority, highest first:
  - rst=0 → 0.
  - readN_reg >= NUM_REGS → 0.
  - BYPASS=1 and write_en=1 and write_reg==readN_reg → write_data.
  - Otherwise → entry[readN_reg].
- Both ports are fully independent. Both may address the same entry, and both may bypass in the same cycle.
- err = 1 when any of the following holds; no other condition raises err:
  - write_en=1 and write_reg >= NUM_REGS. The write is dropped; no entry changes.
  - read1_reg >= NUM_REGS.
  - read2_reg >= NUM_REGS.
- When NUM_REGS is a power of two, every index is legal and err is constant 0.
- err is not sticky. It is forced to 0 while rst=0.

## Timing
- Reset:
  - On rst falling, all entries clear to 0 immediately, with no clk edge needed.
  - read1_data, read2_data and err read 0 throughout reset.
  - Writes are ignored while rst=0.
- Reset release: the first write can occur on the first rising clk edge at which rst=1.
- Reset mid-operation: a write whose clk edge coincides with or follows an rst assertion is lost. The entry reads 0 afterwards.
- Write latency:
  - BYPASS=0: data becomes visible on the read ports the cycle after the write edge.
  - BYPASS=1: data is visible in the same cycle via bypass, then from storage on the following cycles.
- Read-during-write to a different index: the read returns the stored value; the write has no effect on it.
- Back-to-back writes to the same index: the last one wins. Each read reflects the most recent edge (plus bypass, when enabled).

## Structure
- Shared package rf_pkg:
  - default WIDTH and NUM_REGS constants
  - the clog2-based ADDR_W helper function
- Sub-module rf_entry:
  - one WIDTH-bit row with a write enable and asynchronous active-low clear
  - instantiated NUM_REGS times by a generate loop
- Write decode, read muxes, bypass compare and err logic live in rf_bypass.

## Test plan
- Reset clear:
  - Stimulus: write 0xBEEF to entries 0–7, then pulse rst low between clk edges.
  - Required: all reads return 0x0000 immediately, before any edge, and err=0.
- Basic write/read:
  - Stimulus: write 0x1234 to r3. Next cycle, read1_reg=3, read2_reg=3.
  - Required: both ports return 0x1234.
  - Required: an unwritten r4 reads 0x0000.
- Bypass:
  - BYPASS=1: r5 holds 0x00AA. Write 0x5555 to r5 while read1_reg=5. Required: read1_data=0x5555 in the same cycle.
  - BYPASS=0: same stimulus. Required: read1_data=0x00AA in the write cycle and 0x5555 in the next cycle.
- Dual port, same cycle:
  - Stimulus: read1_reg=2, read2_reg=6 while writing 0x7777 to r2.
  - Required (BYPASS=1): read1_data=0x7777, read2_data=old r6.
- Out-of-range with NUM_REGS=6:
  - Write 0xFFFF to index 7. Required: err=1 and no entry changes; a sweep of all entries shows the old values.
  - read2_reg=6. Required: read2_data=0 and err=1.
- Mid-write reset:
  - Stimulus: assert rst low in the same cycle that write_en=1 to r1 with 0x4321.
  - Required: r1 reads 0x0000 after release.
